// File: rtl/action_pkg.sv
// Shared constants for the action engine: opcodes, action field layout,
// container widths and the default per-container action width.
package action_pkg;

    // per-container action word layout: {op[24:21], srcA[20:16], imm[15:0]}
    localparam int ACT_LEN  = 25;
    localparam int OP_LSB   = 21;
    localparam int OP_W     = 4;
    localparam int SRCA_LSB = 16;
    localparam int SRC_W    = 5;
    localparam int IMM_LSB  = 0;
    localparam int IMM_W    = 16;

    // container width classes
    localparam int W6B = 48;
    localparam int W4B = 32;
    localparam int W2B = 16;

    // opcodes; anything not listed behaves as NOP
    localparam logic [OP_W-1:0] OP_NOP     = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD     = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB     = 4'h2;
    localparam logic [OP_W-1:0] OP_ADDI    = 4'h3;
    localparam logic [OP_W-1:0] OP_SET     = 4'h4;
    localparam logic [OP_W-1:0] OP_COPY    = 4'h5;
    localparam logic [OP_W-1:0] OP_DISCARD = 4'hF;

endpackage

// File: rtl/action_alu.sv
// Combinational per-container ALU. imm is zero-extended to DATA_WIDTH.
// Build option: ACTION_ENGINE_SAT_EN makes ADD/ADDI clamp to all-ones and
// SUB clamp to zero instead of wrapping.
module action_alu
    import action_pkg::*;
#(
    parameter int DATA_WIDTH = W4B
) (
    input  logic [OP_W-1:0]       i_op,
    input  logic [DATA_WIDTH-1:0] i_keep,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [IMM_W-1:0]      i_imm,
    output logic [DATA_WIDTH-1:0] o_res
);

    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_add_ab;
    logic [DATA_WIDTH-1:0] w_add_ai;
    logic [DATA_WIDTH-1:0] w_sub_ab;
    logic [DATA_WIDTH-1:0] w_add;
    logic [DATA_WIDTH-1:0] w_addi;
    logic [DATA_WIDTH-1:0] w_sub;

    assign w_imm    = DATA_WIDTH'(i_imm);
    assign w_add_ab = i_a + i_b;
    assign w_add_ai = i_a + w_imm;
    assign w_sub_ab = i_a - i_b;

`ifdef ACTION_ENGINE_SAT_EN
    // an unsigned sum that wrapped is smaller than its first addend
    assign w_add  = (w_add_ab < i_a) ? '1 : w_add_ab;
    assign w_addi = (w_add_ai < i_a) ? '1 : w_add_ai;
    assign w_sub  = (i_a < i_b)      ? '0 : w_sub_ab;
`else
    assign w_add  = w_add_ab;
    assign w_addi = w_add_ai;
    assign w_sub  = w_sub_ab;
`endif

    // opcode dispatch; unknown opcodes keep the container
    always_comb begin
        o_res = i_keep;
        case (i_op)
            OP_ADD:  o_res = w_add;
            OP_SUB:  o_res = w_sub;
            OP_ADDI: o_res = w_addi;
            OP_SET:  o_res = w_imm;
            OP_COPY: o_res = i_a;
            default: o_res = i_keep;
        endcase
    end

endmodule

// File: rtl/action_engine_pipe.sv
// Two-stage action engine. S1 registers the PHV, decoded actions and the
// operands selected from the incoming PHV; S2 runs one action_alu per
// container and registers the modified PHV. Elastic handshake with a
// two-entry skid formed by the two stages.
// Build option: ACTION_ENGINE_SAT_EN (saturating arithmetic, see action_alu).
module action_engine_pipe
    import action_pkg::*;
#(
    parameter  int NUM_6B      = 8,
    parameter  int NUM_4B      = 8,
    parameter  int NUM_2B      = 8,
    parameter  int META_LEN    = 356,
    parameter  int ACT_LEN     = action_pkg::ACT_LEN,
    parameter  int DISCARD_BIT = 128,
    localparam int PHV_LEN     = 48*NUM_6B + 32*NUM_4B + 16*NUM_2B + META_LEN,
    localparam int ACTW        = ACT_LEN*(NUM_6B + NUM_4B + NUM_2B + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid_in,
    input  logic [ACTW-1:0]    action_in,
    input  logic               action_valid_in,
    output logic               ready_out,
    output logic [PHV_LEN-1:0] phv_out,
    output logic               phv_valid_out,
    input  logic               ready_in,
    output logic [31:0]        pkt_cnt,
    output logic [15:0]        err_cnt
);

    // PHV and action slot offsets: meta lowest, then 2B, 4B, 6B
    localparam int OFF_2B  = META_LEN;
    localparam int OFF_4B  = OFF_2B + W2B*NUM_2B;
    localparam int OFF_6B  = OFF_4B + W4B*NUM_4B;
    localparam int AOFF_2B = ACT_LEN;
    localparam int AOFF_4B = ACT_LEN*(1 + NUM_2B);
    localparam int AOFF_6B = ACT_LEN*(1 + NUM_2B + NUM_4B);

    logic               r_s1_valid;
    logic [PHV_LEN-1:0] r_s1_phv;
    logic [OP_W-1:0]    r_s1_meta_op;
    logic               r_s2_valid;
    logic [PHV_LEN-1:0] r_phv_out;
    logic [31:0]        r_pkt_cnt;
    logic [15:0]        r_err_cnt;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_accept;
    logic               w_load;
    logic               w_mismatch;
    logic [PHV_LEN-1:0] w_next;
    logic [META_LEN-1:0] w_meta;
    logic               w_unused_meta_act;

    assign w_s2_adv   = ~r_s2_valid | ready_in;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign ready_out  = ~r_s1_valid | ~r_s2_valid | ready_in;
    assign w_accept   = phv_valid_in & action_valid_in & ready_out;
    assign w_load     = w_accept & w_s1_adv;
    assign w_mismatch = ready_out & (phv_valid_in ^ action_valid_in);

    assign phv_out       = r_phv_out;
    assign phv_valid_out = r_s2_valid;
    assign pkt_cnt       = r_pkt_cnt;
    assign err_cnt       = r_err_cnt;

    // only the opcode of the metadata action has a meaning
    assign w_unused_meta_act = ^action_in[OP_LSB-1:0];

    // S1 valid: refilled from the input whenever S1 is free to move
    always_ff @(posedge clk) begin
        if (!rst_n)        r_s1_valid <= 1'b0;
        else if (w_s1_adv) r_s1_valid <= w_accept;
    end

    // S1 data capture on acceptance
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_s1_phv     <= phv_in;
            r_s1_meta_op <= action_in[OP_LSB +: OP_W];
        end
    end

    // metadata passes through; the discard opcode raises the discard flag
    always_comb begin
        w_meta = r_s1_phv[META_LEN-1:0];
        if (r_s1_meta_op == OP_DISCARD) w_meta[DISCARD_BIT] = 1'b1;
    end
    assign w_next[META_LEN-1:0] = w_meta;

    for (genvar g = 0; g < NUM_2B; g++) begin : g_2b
        logic [SRC_W-1:0] w_sa, w_sb;
        logic [W2B-1:0]   w_a, w_b, w_res, r_a, r_b;
        logic [OP_W-1:0]  r_op;
        logic [IMM_W-1:0] r_imm;

        assign w_sa = action_in[AOFF_2B + ACT_LEN*g + SRCA_LSB +: SRC_W];
        assign w_sb = action_in[AOFF_2B + ACT_LEN*g + IMM_LSB  +: SRC_W];

        // operand fetch within the 2B class; out-of-range index reads zero
        always_comb begin
            w_a = '0;
            w_b = '0;
            if (int'(w_sa) < NUM_2B) w_a = phv_in[OFF_2B + W2B*int'(w_sa) +: W2B];
            if (int'(w_sb) < NUM_2B) w_b = phv_in[OFF_2B + W2B*int'(w_sb) +: W2B];
        end

        // S1 capture of decoded action and operands
        always_ff @(posedge clk) begin
            if (w_load) begin
                r_op  <= action_in[AOFF_2B + ACT_LEN*g + OP_LSB  +: OP_W];
                r_imm <= action_in[AOFF_2B + ACT_LEN*g + IMM_LSB +: IMM_W];
                r_a   <= w_a;
                r_b   <= w_b;
            end
        end

        action_alu #(.DATA_WIDTH(W2B)) u_alu (
            .i_op   (r_op),
            .i_keep (r_s1_phv[OFF_2B + W2B*g +: W2B]),
            .i_a    (r_a),
            .i_b    (r_b),
            .i_imm  (r_imm),
            .o_res  (w_res)
        );
        assign w_next[OFF_2B + W2B*g +: W2B] = w_res;
    end

    for (genvar g = 0; g < NUM_4B; g++) begin : g_4b
        logic [SRC_W-1:0] w_sa, w_sb;
        logic [W4B-1:0]   w_a, w_b, w_res, r_a, r_b;
        logic [OP_W-1:0]  r_op;
        logic [IMM_W-1:0] r_imm;

        assign w_sa = action_in[AOFF_4B + ACT_LEN*g + SRCA_LSB +: SRC_W];
        assign w_sb = action_in[AOFF_4B + ACT_LEN*g + IMM_LSB  +: SRC_W];

        // operand fetch within the 4B class; out-of-range index reads zero
        always_comb begin
            w_a = '0;
            w_b = '0;
            if (int'(w_sa) < NUM_4B) w_a = phv_in[OFF_4B + W4B*int'(w_sa) +: W4B];
            if (int'(w_sb) < NUM_4B) w_b = phv_in[OFF_4B + W4B*int'(w_sb) +: W4B];
        end

        // S1 capture of decoded action and operands
        always_ff @(posedge clk) begin
            if (w_load) begin
                r_op  <= action_in[AOFF_4B + ACT_LEN*g + OP_LSB  +: OP_W];
                r_imm <= action_in[AOFF_4B + ACT_LEN*g + IMM_LSB +: IMM_W];
                r_a   <= w_a;
                r_b   <= w_b;
            end
        end

        action_alu #(.DATA_WIDTH(W4B)) u_alu (
            .i_op   (r_op),
            .i_keep (r_s1_phv[OFF_4B + W4B*g +: W4B]),
            .i_a    (r_a),
            .i_b    (r_b),
            .i_imm  (r_imm),
            .o_res  (w_res)
        );
        assign w_next[OFF_4B + W4B*g +: W4B] = w_res;
    end

    for (genvar g = 0; g < NUM_6B; g++) begin : g_6b
        logic [SRC_W-1:0] w_sa, w_sb;
        logic [W6B-1:0]   w_a, w_b, w_res, r_a, r_b;
        logic [OP_W-1:0]  r_op;
        logic [IMM_W-1:0] r_imm;

        assign w_sa = action_in[AOFF_6B + ACT_LEN*g + SRCA_LSB +: SRC_W];
        assign w_sb = action_in[AOFF_6B + ACT_LEN*g + IMM_LSB  +: SRC_W];

        // operand fetch within the 6B class; out-of-range index reads zero
        always_comb begin
            w_a = '0;
            w_b = '0;
            if (int'(w_sa) < NUM_6B) w_a = phv_in[OFF_6B + W6B*int'(w_sa) +: W6B];
            if (int'(w_sb) < NUM_6B) w_b = phv_in[OFF_6B + W6B*int'(w_sb) +: W6B];
        end

        // S1 capture of decoded action and operands
        always_ff @(posedge clk) begin
            if (w_load) begin
                r_op  <= action_in[AOFF_6B + ACT_LEN*g + OP_LSB  +: OP_W];
                r_imm <= action_in[AOFF_6B + ACT_LEN*g + IMM_LSB +: IMM_W];
                r_a   <= w_a;
                r_b   <= w_b;
            end
        end

        action_alu #(.DATA_WIDTH(W6B)) u_alu (
            .i_op   (r_op),
            .i_keep (r_s1_phv[OFF_6B + W6B*g +: W6B]),
            .i_a    (r_a),
            .i_b    (r_b),
            .i_imm  (r_imm),
            .o_res  (w_res)
        );
        assign w_next[OFF_6B + W6B*g +: W6B] = w_res;
    end

    // S2 output register: holds while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_phv_out  <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_phv_out <= w_next;
        end
    end

    // emitted-PHV counter (wrapping) and saturating mismatch counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            if (r_s2_valid && ready_in)            r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_mismatch && (r_err_cnt != '1))   r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

endmodule
